data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Data-memory responder for the single-cycle/multi-cycle datapath. It is the target side of the MemRead/MemWrite strobes the control unit issues for lw/sw. It accepts one word access at a time, models a configurable access latency, and returns read data with a one-cycle MemReady completion pulse. Illegal accesses are flagged on AccessErr.

Parameters:
DATA_W, 32, data word width in bits
DEPTH, 64, number of DATA_W-bit words stored; legal word index 0..DEPTH-1
LATENCY, 2, wait cycles between acceptance and completion; legal range 0..15

Ports:
clk  in  1  single clock; all state changes on rising edge
rst_n  in  1  asynchronous, active-low reset
MemRead  in  1  read request; held by initiator until MemReady seen
MemWrite  in  1  write request; held by initiator until MemReady seen
Addr  in  32  byte address; word index = Addr[31:2]
WriteData  in  DATA_W  store data, sampled at acceptance
ReadData  out  DATA_W  load data; valid while MemReady=1
MemReady  out  1  one-cycle completion pulse
MemBusy  out  1  access in progress
AccessErr  out  1  error status of completing access; valid while MemReady=1

Behaviour:
- Reset: asynchronous on rst_n low; all outputs 0, FSM in IDLE, storage array cleared to 0, latched request discarded.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE: on a rising edge with MemRead|MemWrite=1 (acceptance edge E0), latch Addr, WriteData and op. Go to WAIT with counter=LATENCY, or directly to RESP if LATENCY=0.
- WAIT: decrement the counter each edge; go to RESP on the edge where the count reaches 0.
- RESP lasts exactly one cycle, then returns to IDLE unconditionally.
- Timing: MemReady=1 exactly during the cycle following edge E0+LATENCY. Throughput is 1 access per LATENCY+2 cycles.
- MemBusy=1 from the cycle after E0 through the MemReady cycle inclusive.
- Requests are sampled only in IDLE. Changes on MemRead, MemWrite, Addr or WriteData after E0 are ignored.
- Error conditions:
  - Addr[1:0]!=0 (misaligned)
  - word index >= DEPTH (out of range)
  - MemRead=1 and MemWrite=1 at E0
- An erroring access completes with normal timing: MemReady=1, AccessErr=1, ReadData=0, and no array write.
- Write commit: the array word is updated on the edge entering RESP. A reset before that edge aborts the write with no commit.
- Read: ReadData is loaded on the edge entering RESP from the array contents at that edge. ReadData holds its value after MemReady drops.
- Write completion: ReadData is unchanged and AccessErr=0.
- AccessErr is 0 whenever MemReady=0.
- No read/write collision is possible, because only one access is in flight.

Test Plan:
1. Reset, then LATENCY=2, MemRead=1 with Addr=0x10 -> MemBusy=1 in cycles 1-3 after E0, MemReady=1 only in cycle 3, ReadData=0x00000000, AccessErr=0.
2. Write 0xDEADBEEF to Addr=0x20, drop the request after MemReady, then read 0x20 -> ReadData=0xDEADBEEF. Each access takes 4 cycles from request to completion. Repeat with LATENCY=0 -> MemReady in cycle 1 after E0.
3. Issue three erroring accesses:
   - write 0x11111111 to Addr=0x22 (misaligned)
   - read Addr=0x100 (index 64, out of range)
   - MemRead=MemWrite=1 at Addr=0x20
   -> each gives MemReady with AccessErr=1 and ReadData=0. A following read of 0x20 still returns 0xDEADBEEF.
4. Accept a read of 0x20, then change Addr to 0x24 and pulse MemWrite during WAIT -> response is ReadData=0xDEADBEEF and no write occurs at 0x24.
5. Write 0x55 to Addr=0x04 and assert rst_n=0 in the cycle after E0 -> all outputs 0 immediately. After release, a read of 0x04 returns 0 and a read of 0x20 returns 0 (array cleared).

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory target for MemRead/MemWrite; completes in LATENCY+1 cycles after acceptance.
// One access in flight; requests are held by the initiator until MemReady, so inputs are ignored while busy.
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              MemBusy,
    output logic              AccessErr
);
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdat;
    logic              acc_rd;
    logic              acc_wr;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic              enter_resp;
    logic              mem_we;

    // With zero latency the access resolves on the acceptance edge itself, so
    // the live request is used in IDLE and the latched copy afterwards.
    always_comb begin
        acc_addr = addr_q;
        acc_wdat = wdat_q;
        acc_rd   = rd_q;
        acc_wr   = wr_q;
        if (state_q == IDLE) begin
            acc_addr = Addr;
            acc_wdat = WriteData;
            acc_rd   = MemRead;
            acc_wr   = MemWrite;
        end
        acc_idx = acc_addr[IDX_W+1:2];
        acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W) || (acc_rd && acc_wr);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d = Addr;
                    wdat_d = WriteData;
                    rd_d   = MemRead;
                    wr_d   = MemWrite;
                    if (LAT == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Write completions leave ReadData untouched; errors force it to zero.
        mem_we = enter_resp && acc_wr && !acc_err;
        if (enter_resp) begin
            err_d = acc_err;
            if (acc_err) begin
                rdata_d = '0;
            end else if (acc_rd) begin
                rdata_d = mem_q[acc_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[acc_idx] <= acc_wdat;
        end
    end

    assign ReadData  = rdata_q;
    assign MemReady  = (state_q == RESP);
    assign MemBusy   = (state_q != IDLE);
    assign AccessErr = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=0 instances, scoreboard-checked responses.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_i   [2];
    logic        wr_i   [2];
    logic [31:0] addr_i [2];
    logic [31:0] wdat_i [2];
    logic [31:0] rdat_o [2];
    logic        rdy_o  [2];
    logic        busy_o [2];
    logic        err_o  [2];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t exp_q0 [$];
    exp_t exp_q1 [$];

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(32), .DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(rd_i[0]), .MemWrite(wr_i[0]),
        .Addr(addr_i[0]), .WriteData(wdat_i[0]), .ReadData(rdat_o[0]),
        .MemReady(rdy_o[0]), .MemBusy(busy_o[0]), .AccessErr(err_o[0])
    );

    data_mem_responder #(.DATA_W(32), .DEPTH(64), .LATENCY(0)) dut_l0 (
        .clk(clk), .rst_n(rst_n), .MemRead(rd_i[1]), .MemWrite(wr_i[1]),
        .Addr(addr_i[1]), .WriteData(wdat_i[1]), .ReadData(rdat_o[1]),
        .MemReady(rdy_o[1]), .MemBusy(busy_o[1]), .AccessErr(err_o[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: every completion pops the oldest expectation for that instance.
    always @(negedge clk) begin
        if (rst_n && rdy_o[0]) begin
            if (exp_q0.size() == 0) begin
                chk("unexpected_rsp_l2", 64'(rdy_o[0]), 64'd0);
            end else begin
                exp_t e;
                e = exp_q0.pop_front();
                chk("rsp_l2", 64'({err_o[0], rdat_o[0]}), 64'({e.err, e.dat}));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rdy_o[1]) begin
            if (exp_q1.size() == 0) begin
                chk("unexpected_rsp_l0", 64'(rdy_o[1]), 64'd0);
            end else begin
                exp_t e;
                e = exp_q1.pop_front();
                chk("rsp_l0", 64'({err_o[1], rdat_o[1]}), 64'({e.err, e.dat}));
            end
        end
    end

    // Called at posedge+1 with the DUT idle; the next posedge is the acceptance edge.
    task automatic access(input int k, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                          input logic glitch, input string nm);
        int   cyc;
        logic busy_ok;
        rd_i[k]   = rd;
        wr_i[k]   = wr;
        addr_i[k] = a;
        wdat_i[k] = wd;
        if (k == 0) exp_q0.push_back('{dat: ed, err: ee});
        else        exp_q1.push_back('{dat: ed, err: ee});
        cyc     = 0;
        busy_ok = 1'b1;
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!busy_o[k]) busy_ok = 1'b0;
            if (glitch && cyc == 1) begin
                addr_i[k] = 32'h24;
                wr_i[k]   = 1'b1;
                wdat_i[k] = 32'h9999_9999;
            end
            if (glitch && cyc == 2) wr_i[k] = 1'b0;
            if (rdy_o[k] || cyc >= 40) break;
        end
        chk({nm, "_latency"}, 64'(cyc), (k == 0) ? 64'd3 : 64'd1);
        chk({nm, "_busy"}, 64'(busy_ok), 64'd1);
        rd_i[k] = 1'b0;
        wr_i[k] = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_after"}, 64'({rdy_o[k], busy_o[k], err_o[k], rdat_o[k]}), 64'({3'b000, ed}));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rd_i[k]   = 1'b0;
            wr_i[k]   = 1'b0;
            addr_i[k] = '0;
            wdat_i[k] = '0;
        end
        #12;
        chk("reset_l2", 64'({rdy_o[0], busy_o[0], err_o[0], rdat_o[0]}), 64'd0);
        chk("reset_l0", 64'({rdy_o[1], busy_o[1], err_o[1], rdat_o[1]}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LATENCY=2: basic read, write/readback, top word boundary
        access(0, 1, 0, 32'h10, 32'h0,        32'h0000_0000, 0, 0, "rd10");
        access(0, 0, 1, 32'h20, 32'hDEADBEEF, 32'h0000_0000, 0, 0, "wr20");
        access(0, 1, 0, 32'h20, 32'h0,        32'hDEADBEEF, 0, 0, "rd20");
        access(0, 0, 1, 32'hFC, 32'hCAFEF00D, 32'hDEADBEEF, 0, 0, "wrFC");
        access(0, 1, 0, 32'hFC, 32'h0,        32'hCAFEF00D, 0, 0, "rdFC");

        // Error accesses: misaligned, out of range, both strobes
        access(0, 0, 1, 32'h22,  32'h1111_1111, 32'h0, 1, 0, "err_misalign");
        access(0, 1, 0, 32'h100, 32'h0,         32'h0, 1, 0, "err_range");
        access(0, 1, 1, 32'h20,  32'h2222_2222, 32'h0, 1, 0, "err_both");
        access(0, 1, 0, 32'h20,  32'h0,         32'hDEADBEEF, 0, 0, "rd20_kept");

        // Request changes after acceptance are ignored
        access(0, 1, 0, 32'h20, 32'h0, 32'hDEADBEEF, 0, 1, "rd20_glitch");
        access(0, 1, 0, 32'h24, 32'h0, 32'h0000_0000, 0, 0, "rd24_nowrite");
        access(0, 1, 0, 32'h20, 32'h0, 32'hDEADBEEF, 0, 0, "rd20_again");

        // LATENCY=0 instance
        access(1, 0, 1, 32'h20,  32'hDEADBEEF, 32'h0,        0, 0, "l0_wr20");
        access(1, 1, 0, 32'h20,  32'h0,        32'hDEADBEEF, 0, 0, "l0_rd20");
        access(1, 1, 0, 32'h100, 32'h0,        32'h0,        1, 0, "l0_err_range");

        // Reset during an in-flight write: outputs clear at once, array is wiped
        rd_i[0]   = 1'b0;
        wr_i[0]   = 1'b1;
        addr_i[0] = 32'h04;
        wdat_i[0] = 32'h55;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy_o[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 64'({rdy_o[0], busy_o[0], err_o[0], rdat_o[0]}), 64'd0);
        wr_i[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1, 0, 32'h04, 32'h0, 32'h0, 0, 0, "rd04_after_rst");
        access(0, 1, 0, 32'h20, 32'h0, 32'h0, 0, 0, "rd20_cleared");

        repeat (2) @(posedge clk);
        chk("pending_l2", 64'(exp_q0.size()), 64'd0);
        chk("pending_l0", 64'(exp_q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
